// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between the instruction-fetch
// requester and the load/store requester. Each request is latched in IDLE and
// then runs a fixed MEM_LAT-cycle ACCESS phase. A one-cycle RESP phase follows,
// carrying the acknowledge and the registered read data.
// Optional feature macro: ARB_ROUND_ROBIN_EN. When it is defined, contended
// grants alternate between the two ports. When it is undefined, the data port
// always wins a contended grant.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_d
);

    // Reject a latency the 4-bit counter cannot represent, or a zero latency.
    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
            $error("mem_arbiter: MEM_LAT must be in the range 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              grant_d_q, grant_d_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_data;
`ifdef ARB_ROUND_ROBIN_EN
    logic              rr_last_q, rr_last_d;
`endif

    // Next-state and next-output decode; every output is a register loaded from here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        grant_d_d   = grant_d_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d   = rr_last_q;
        // rr_last_q = 1 means the data port was granted last, so the fetch port wins a tie.
        pick_data   = d_req && (!i_req || !rr_last_q);
`else
        pick_data   = d_req;
`endif

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d     = ACCESS;
                    cnt_d       = LAT;
                    grant_d_d   = pick_data;
                    we_d        = pick_data && d_we;
                    mem_addr_d  = pick_data ? d_addr : i_addr;
                    mem_re_d    = !(pick_data && d_we);
                    mem_we_d    = pick_data && d_we;
                    mem_wdata_d = (pick_data && d_we) ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_d   = pick_data;
`endif
                end
            end
            ACCESS: begin
                cnt_d    = cnt_q - 4'd1;
                mem_we_d = 1'b0;
                if (cnt_q == 4'd1) begin
                    state_d     = RESP;
                    mem_re_d    = 1'b0;
                    mem_wdata_d = '0;
                    if (!we_q) begin
                        if (grant_d_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    if (grant_d_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        i_ack_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset overrides any pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            grant_d_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            grant_d_q   <= grant_d_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q   <= rr_last_d;
`endif
        end
    end

    assign i_rdata   = i_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign grant_d   = grant_d_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two instances are checked: one with MEM_LAT=1 and one with MEM_LAT=3.
// Each instance has its own memory model. The model only drives valid read data
// in the MEM_LAT-th consecutive cycle of mem_re.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        i_req_1, d_req_1, d_we_1;
    logic [31:0] i_addr_1, d_addr_1, d_wdata_1, mem_rdata_1;
    logic [31:0] i_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;
    logic        i_ack_1, d_ack_1, mem_re_1, mem_we_1, busy_1, grant_d_1;

    logic        i_req_3, d_req_3, d_we_3;
    logic [31:0] i_addr_3, d_addr_3, d_wdata_3, mem_rdata_3;
    logic [31:0] i_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3;
    logic        i_ack_3, d_ack_3, mem_re_3, mem_we_3, busy_3, grant_d_3;

    int compared = 0;
    int mismatched = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req_1), .i_addr(i_addr_1), .i_rdata(i_rdata_1), .i_ack(i_ack_1),
        .d_req(d_req_1), .d_we(d_we_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_rdata(d_rdata_1), .d_ack(d_ack_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_re(mem_re_1), .mem_we(mem_we_1),
        .mem_rdata(mem_rdata_1), .busy(busy_1), .grant_d(grant_d_1)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .i_req(i_req_3), .i_addr(i_addr_3), .i_rdata(i_rdata_3), .i_ack(i_ack_3),
        .d_req(d_req_3), .d_we(d_we_3), .d_addr(d_addr_3), .d_wdata(d_wdata_3),
        .d_rdata(d_rdata_3), .d_ack(d_ack_3),
        .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_re(mem_re_3), .mem_we(mem_we_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3), .grant_d(grant_d_3)
    );

    // Memory models: write on mem_we, count consecutive mem_re cycles to gate read data.
    logic [31:0] mem1 [0:255] = '{default: 32'h0};
    logic [31:0] mem3 [0:255] = '{default: 32'h0};
    logic [3:0]  re_cnt1 = 4'd0;
    logic [3:0]  re_cnt3 = 4'd0;

    always @(posedge clk) begin
        if (mem_we_1) mem1[mem_addr_1[7:0]] <= mem_wdata_1;
        if (mem_re_1) re_cnt1 <= re_cnt1 + 4'd1; else re_cnt1 <= 4'd0;
        if (mem_we_3) mem3[mem_addr_3[7:0]] <= mem_wdata_3;
        if (mem_re_3) re_cnt3 <= re_cnt3 + 4'd1; else re_cnt3 <= 4'd0;
    end

    assign mem_rdata_1 = (mem_re_1 && re_cnt1 == 4'd0) ? mem1[mem_addr_1[7:0]] : 32'hBAD0_BAD0;
    assign mem_rdata_3 = (mem_re_3 && re_cnt3 == 4'd2) ? mem3[mem_addr_3[7:0]] : 32'hBAD0_BAD0;

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset holds everything at zero even while requests are asserted.
    task automatic test_reset();
        reset = 1'b1;
        i_req_1 = 1'b1; i_addr_1 = 32'h10;
        d_req_3 = 1'b1; d_we_3 = 1'b0; d_addr_3 = 32'h40;
        step(); step();
        compared++; if (i_ack_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_i_ack: got %0h want 0", i_ack_1); end
        compared++; if (d_ack_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_d_ack: got %0h want 0", d_ack_1); end
        compared++; if (mem_re_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_re: got %0h want 0", mem_re_1); end
        compared++; if (mem_we_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_we: got %0h want 0", mem_we_1); end
        compared++; if (busy_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0h want 0", busy_1); end
        compared++; if (grant_d_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_grant_d: got %0h want 0", grant_d_1); end
        compared++; if (i_rdata_1 !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_i_rdata: got %0h want 0", i_rdata_1); end
        compared++; if (d_rdata_1 !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_d_rdata: got %0h want 0", d_rdata_1); end
        compared++; if (mem_addr_1 !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_addr: got %0h want 0", mem_addr_1); end
        compared++; if (mem_wdata_1 !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mem_wdata: got %0h want 0", mem_wdata_1); end
        compared++; if (busy_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_lat3: got %0h want 0", busy_3); end
        compared++; if (mem_re_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mem_re_lat3: got %0h want 0", mem_re_3); end
        reset = 1'b0;
        i_req_1 = 1'b0;
        d_req_3 = 1'b0;
        step();
        compared++; if (busy_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req_not_latched: got %0h want 0", busy_1); end
    endtask

    // Preload 0x10 with a store, then fetch it with MEM_LAT=1.
    task automatic test_fetch();
        d_req_1 = 1'b1; d_we_1 = 1'b1; d_addr_1 = 32'h10; d_wdata_1 = 32'hDEADBEEF;
        step();
        d_req_1 = 1'b0; d_we_1 = 1'b0;
        step();
        compared++; if (d_ack_1 !== 1'b1) begin mismatched++; $display("[TB] FAIL preload_d_ack: got %0h want 1", d_ack_1); end
        compared++; if (d_rdata_1 !== 32'h0) begin mismatched++; $display("[TB] FAIL store_keeps_d_rdata: got %0h want 0", d_rdata_1); end
        step();
        i_req_1 = 1'b1; i_addr_1 = 32'h10;
        step();
        i_req_1 = 1'b0; i_addr_1 = 32'h0;
        compared++; if (mem_re_1 !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_mem_re: got %0h want 1", mem_re_1); end
        compared++; if (mem_addr_1 !== 32'h10) begin mismatched++; $display("[TB] FAIL fetch_mem_addr: got %0h want 10", mem_addr_1); end
        compared++; if (grant_d_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_grant_d: got %0h want 0", grant_d_1); end
        compared++; if (i_ack_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_early_ack: got %0h want 0", i_ack_1); end
        step();
        compared++; if (i_ack_1 !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_i_ack: got %0h want 1", i_ack_1); end
        compared++; if (i_rdata_1 !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL fetch_i_rdata: got %0h want deadbeef", i_rdata_1); end
        compared++; if (d_ack_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_no_d_ack: got %0h want 0", d_ack_1); end
        step();
        compared++; if (busy_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_busy_after: got %0h want 0", busy_1); end
        compared++; if (i_ack_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_ack_one_cycle: got %0h want 0", i_ack_1); end
    endtask

    // Store 0x1234 to 0x40 and read it back with MEM_LAT=3.
    task automatic test_store_load();
        d_req_3 = 1'b1; d_we_3 = 1'b1; d_addr_3 = 32'h40; d_wdata_3 = 32'h1234;
        step();
        d_req_3 = 1'b0; d_we_3 = 1'b0; d_wdata_3 = 32'h5555AAAA;
        compared++; if (mem_we_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL store_mem_we_c1: got %0h want 1", mem_we_3); end
        compared++; if (mem_wdata_3 !== 32'h1234) begin mismatched++; $display("[TB] FAIL store_mem_wdata: got %0h want 1234", mem_wdata_3); end
        compared++; if (mem_re_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL store_mem_re: got %0h want 0", mem_re_3); end
        step();
        compared++; if (mem_we_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL store_mem_we_c2: got %0h want 0", mem_we_3); end
        compared++; if (busy_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL store_busy_c2: got %0h want 1", busy_3); end
        step();
        compared++; if (d_ack_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL store_early_ack: got %0h want 0", d_ack_3); end
        compared++; if (mem_we_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL store_mem_we_c3: got %0h want 0", mem_we_3); end
        step();
        compared++; if (d_ack_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL store_d_ack_c4: got %0h want 1", d_ack_3); end
        compared++; if (mem_wdata_3 !== 32'h0) begin mismatched++; $display("[TB] FAIL store_wdata_cleared: got %0h want 0", mem_wdata_3); end
        step();
        d_req_3 = 1'b1; d_we_3 = 1'b0; d_addr_3 = 32'h40;
        step();
        d_req_3 = 1'b0;
        compared++; if (mem_re_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL load_mem_re_c1: got %0h want 1", mem_re_3); end
        step(); step();
        compared++; if (mem_re_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL load_mem_re_c3: got %0h want 1", mem_re_3); end
        compared++; if (d_ack_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL load_early_ack: got %0h want 0", d_ack_3); end
        step();
        compared++; if (d_ack_3 !== 1'b1) begin mismatched++; $display("[TB] FAIL load_d_ack_c4: got %0h want 1", d_ack_3); end
        compared++; if (d_rdata_3 !== 32'h1234) begin mismatched++; $display("[TB] FAIL load_d_rdata: got %0h want 1234", d_rdata_3); end
        compared++; if (mem_re_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL load_mem_re_off: got %0h want 0", mem_re_3); end
        step();
    endtask

    // Both requests are held for cycles 0..7, so grants land in cycles 0, 3 and 6.
    task automatic test_back_to_back_contention();
        logic exp_ack, exp_d;
        int   idx;
        i_req_1 = 1'b1; i_addr_1 = 32'h10;
        d_req_1 = 1'b1; d_we_1 = 1'b0; d_addr_1 = 32'h40;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 8) begin
                i_req_1 = 1'b0;
                d_req_1 = 1'b0;
            end
            exp_ack = ((c % 3) == 2);
            idx = (c - 1) / 3;
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = ((idx % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            compared++; if (d_ack_1 !== (exp_ack && exp_d)) begin mismatched++; $display("[TB] FAIL contend_d_ack c%0d: got %0h want %0h", c, d_ack_1, exp_ack && exp_d); end
            compared++; if (i_ack_1 !== (exp_ack && !exp_d)) begin mismatched++; $display("[TB] FAIL contend_i_ack c%0d: got %0h want %0h", c, i_ack_1, exp_ack && !exp_d); end
            compared++; if (grant_d_1 !== exp_d) begin mismatched++; $display("[TB] FAIL contend_grant_d c%0d: got %0h want %0h", c, grant_d_1, exp_d); end
        end
        step();
        compared++; if (busy_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL contend_idle_after: got %0h want 0", busy_1); end
    endtask

    // A reset during a MEM_LAT=3 fetch aborts it; a fresh request afterwards completes.
    task automatic test_reset_mid_read();
        i_req_3 = 1'b1; i_addr_3 = 32'h40;
        step();
        i_req_3 = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        compared++; if (busy_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %0h want 0", busy_3); end
        compared++; if (mem_re_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_mem_re: got %0h want 0", mem_re_3); end
        compared++; if (mem_addr_3 !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_mem_addr: got %0h want 0", mem_addr_3); end
        compared++; if (i_ack_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_i_ack: got %0h want 0", i_ack_3); end
        compared++; if (d_rdata_3 !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_d_rdata: got %0h want 0", d_rdata_3); end
        compared++; if (grant_d_3 !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_grant_d: got %0h want 0", grant_d_3); end
        i_req_3 = 1'b1; i_addr_3 = 32'h40;
        for (int c = 4; c <= 8; c++) begin
            step();
            if (c == 4) i_req_3 = 1'b0;
            compared++; if (i_ack_3 !== (c == 7)) begin mismatched++; $display("[TB] FAIL midrst_new_i_ack c%0d: got %0h want %0h", c, i_ack_3, (c == 7)); end
            if (c == 7) begin
                compared++; if (i_rdata_3 !== 32'h1234) begin mismatched++; $display("[TB] FAIL midrst_new_i_rdata: got %0h want 1234", i_rdata_3); end
            end
        end
    endtask

    // A load request present for a single cycle still completes exactly once.
    task automatic test_dropped_request();
        d_req_1 = 1'b1; d_we_1 = 1'b0; d_addr_1 = 32'h10;
        step();
        d_req_1 = 1'b0; d_addr_1 = 32'h0;
        step();
        compared++; if (d_ack_1 !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_d_ack: got %0h want 1", d_ack_1); end
        compared++; if (d_rdata_1 !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL drop_d_rdata: got %0h want deadbeef", d_rdata_1); end
        step();
        compared++; if (busy_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_busy_c3: got %0h want 0", busy_1); end
        step();
        compared++; if (busy_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_busy_c4: got %0h want 0", busy_1); end
        compared++; if (d_ack_1 !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_no_second_ack: got %0h want 0", d_ack_1); end
    endtask

    // Run every scenario in order; later tests rely on memory contents written earlier.
    initial begin
        reset = 1'b1;
        i_req_1 = 1'b0; i_addr_1 = 32'h0; d_req_1 = 1'b0; d_we_1 = 1'b0; d_addr_1 = 32'h0; d_wdata_1 = 32'h0;
        i_req_3 = 1'b0; i_addr_3 = 32'h0; d_req_3 = 1'b0; d_we_3 = 1'b0; d_addr_3 = 32'h0; d_wdata_3 = 32'h0;
        $display("[TB] starting mem_arbiter bench");
        test_reset();
        test_fetch();
        test_store_load();
        test_back_to_back_contention();
        test_reset_mid_read();
        test_dropped_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
